// File: rtl/potential_sweeper_pkg.sv
// Shared constants and FSM state encoding for the potential sweeper slice.
package potential_sweeper_pkg;

   localparam int NUM_GROUPS        = 64;
   localparam int NEURONS_PER_GROUP = 16;
   localparam int POT_W             = 8;
   localparam int GROUP_W           = NEURONS_PER_GROUP * POT_W;
   localparam int SEL_W             = $clog2(NUM_GROUPS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STEP,
      S_SETTLE,
      S_STORE
   } state_t;

endpackage

// File: rtl/potential_sweeper_buffer.sv
// Membrane-potential state buffer (GROUPS x GROUP_W) with valid bitmap.
// POTENTIAL_SWEEPER_DBG_EN adds a registered debug read port.
module potential_buffer
   import potential_sweeper_pkg::*;
#(
   parameter int GROUPS  = NUM_GROUPS,
   parameter int GROUP_W = potential_sweeper_pkg::GROUP_W,
   parameter int SEL_W   = potential_sweeper_pkg::SEL_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               wr_en,
   input  logic [SEL_W-1:0]   wr_addr,
   input  logic [GROUP_W-1:0] wr_data,
   input  logic [SEL_W-1:0]   rd_addr,
   output logic [GROUP_W-1:0] rd_data
`ifdef POTENTIAL_SWEEPER_DBG_EN
   ,
   input  logic [SEL_W-1:0]   dbg_sel,
   output logic [GROUP_W-1:0] dbg_potential
`endif
);

   logic [GROUP_W-1:0] mem [GROUPS];
   logic [GROUPS-1:0]  valid;

   // Storage is never reset; the valid bitmap alone decides what is visible.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)     valid <= '0;
      else if (clear) valid <= '0;
      else if (wr_en) valid[wr_addr] <= 1'b1;
   end

   always_comb rd_data = valid[rd_addr] ? mem[rd_addr] : '0;

`ifdef POTENTIAL_SWEEPER_DBG_EN
   always_ff @(posedge clk) begin
      if (!rst_n) dbg_potential <= '0;
      else        dbg_potential <= valid[dbg_sel] ? mem[dbg_sel] : '0;
   end
`endif

endmodule

// File: rtl/potential_sweeper.sv
// Sequencing master for neuron_selector: LOAD -> STEP -> SETTLE -> STORE per time step.
// POTENTIAL_SWEEPER_DBG_EN exposes dbg_sel/dbg_potential from the buffer.
module potential_sweeper
   import potential_sweeper_pkg::*;
#(
   parameter int GROUPS  = NUM_GROUPS,
   parameter int GROUP_W = potential_sweeper_pkg::GROUP_W,
   parameter int SEL_W   = potential_sweeper_pkg::SEL_W,
   parameter int SETTLE  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               clear,
   output logic               busy,
   output logic               done,
   output logic [SEL_W-1:0]   cntrl_potential_in_sel,
   output logic [GROUP_W-1:0] potential_in_16n,
   output logic               potential_load_en,
   output logic               neuron_step,
   output logic [SEL_W-1:0]   cntrl_potential_out_sel,
   input  logic [GROUP_W-1:0] potential_out_16n
`ifdef POTENTIAL_SWEEPER_DBG_EN
   ,
   input  logic [SEL_W-1:0]   dbg_sel,
   output logic [GROUP_W-1:0] dbg_potential
`endif
);

   localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t             state;
   logic [SEL_W-1:0]   cnt;
   logic [SC_W-1:0]    settle_cnt;
   logic [SEL_W-1:0]   rd_addr;
   logic [GROUP_W-1:0] rd_data;
   logic               clear_eff;
   logic               wr_en;

   assign clear_eff = clear && (state == S_IDLE);
   assign wr_en     = (state == S_STORE);
   assign busy      = (state != S_IDLE);

   // Outputs are registered, so the read address looks one group ahead.
   always_comb rd_addr = (state == S_LOAD) ? cnt + SEL_W'(1) : '0;

   potential_buffer #(
      .GROUPS  (GROUPS),
      .GROUP_W (GROUP_W),
      .SEL_W   (SEL_W)
   ) u_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear_eff),
      .wr_en   (wr_en),
      .wr_addr (cnt),
      .wr_data (potential_out_16n),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
`ifdef POTENTIAL_SWEEPER_DBG_EN
      ,
      .dbg_sel       (dbg_sel),
      .dbg_potential (dbg_potential)
`endif
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                   <= S_IDLE;
         cnt                     <= '0;
         settle_cnt              <= '0;
         cntrl_potential_in_sel  <= '0;
         potential_in_16n        <= '0;
         potential_load_en       <= 1'b0;
         neuron_step             <= 1'b0;
         cntrl_potential_out_sel <= '0;
         done                    <= 1'b0;
      end else begin
         cntrl_potential_in_sel  <= '0;
         potential_in_16n        <= '0;
         potential_load_en       <= 1'b0;
         neuron_step             <= 1'b0;
         cntrl_potential_out_sel <= '0;
         done                    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state             <= S_LOAD;
                  cnt               <= '0;
                  potential_load_en <= 1'b1;
                  // A same-cycle clear must already hide group 0.
                  potential_in_16n  <= clear ? '0 : rd_data;
               end
            end
            S_LOAD: begin
               if (cnt == SEL_W'(GROUPS - 1)) begin
                  state       <= S_STEP;
                  cnt         <= '0;
                  neuron_step <= 1'b1;
               end else begin
                  cnt                    <= cnt + SEL_W'(1);
                  cntrl_potential_in_sel <= cnt + SEL_W'(1);
                  potential_in_16n       <= rd_data;
                  potential_load_en      <= 1'b1;
               end
            end
            S_STEP: begin
               if (SETTLE > 0) begin
                  state      <= S_SETTLE;
                  settle_cnt <= SC_W'(SETTLE - 1);
               end else begin
                  state <= S_STORE;
                  cnt   <= '0;
                  done  <= (GROUPS == 1);
               end
            end
            S_SETTLE: begin
               if (settle_cnt == '0) begin
                  state <= S_STORE;
                  cnt   <= '0;
                  done  <= (GROUPS == 1);
               end else begin
                  settle_cnt <= settle_cnt - SC_W'(1);
               end
            end
            S_STORE: begin
               if (cnt == SEL_W'(GROUPS - 1)) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt                     <= cnt + SEL_W'(1);
                  cntrl_potential_out_sel <= cnt + SEL_W'(1);
                  done                    <= (cnt == SEL_W'(GROUPS - 2));
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_potential_sweeper.sv
// Directed bench for potential_sweeper: default SETTLE=2 instance plus a SETTLE=0 instance.
module tb_potential_sweeper;

   logic clk;
   logic rst_n;
   logic start_a, clear_a, start_b, clear_b;

   logic         busy_a, done_a, load_en_a, step_a;
   logic [5:0]   in_sel_a, out_sel_a;
   logic [127:0] pin_a, pout_a;
   logic         busy_b, done_b, load_en_b, step_b;
   logic [5:0]   in_sel_b, out_sel_b;
   logic [127:0] pin_b, pout_b;

   logic [143:0] obs_a, obs_b;

   int checks   = 0;
   int failures = 0;

   // Neuron model: group k returns {16{k}}.
   assign pout_a = {16{2'b00, out_sel_a}};
   assign pout_b = {16{2'b00, out_sel_b}};

   assign obs_a = {busy_a, done_a, load_en_a, step_a, in_sel_a, out_sel_a, pin_a};
   assign obs_b = {busy_b, done_b, load_en_b, step_b, in_sel_b, out_sel_b, pin_b};

   potential_sweeper dut_a (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .start                   (start_a),
      .clear                   (clear_a),
      .busy                    (busy_a),
      .done                    (done_a),
      .cntrl_potential_in_sel  (in_sel_a),
      .potential_in_16n        (pin_a),
      .potential_load_en       (load_en_a),
      .neuron_step             (step_a),
      .cntrl_potential_out_sel (out_sel_a),
      .potential_out_16n       (pout_a)
   );

   potential_sweeper #(.SETTLE(0)) dut_b (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .start                   (start_b),
      .clear                   (clear_b),
      .busy                    (busy_b),
      .done                    (done_b),
      .cntrl_potential_in_sel  (in_sel_b),
      .potential_in_16n        (pin_b),
      .potential_load_en       (load_en_b),
      .neuron_step             (step_b),
      .cntrl_potential_out_sel (out_sel_b),
      .potential_out_16n       (pout_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Cycle c counts from 1 after the edge that samples start.
   function automatic logic [143:0] exp_vec(input int c, input bit zero, input int settle);
      logic         e_done = 1'b0;
      logic         e_le   = 1'b0;
      logic         e_ns   = 1'b0;
      logic [5:0]   e_is   = '0;
      logic [5:0]   e_os   = '0;
      logic [127:0] e_p    = '0;
      int           s0     = 66 + settle;
      if (c <= 64) begin
         e_le = 1'b1;
         e_is = 6'(c - 1);
         e_p  = zero ? '0 : {16{8'(c - 1)}};
      end else if (c == 65) begin
         e_ns = 1'b1;
      end else if (c >= s0) begin
         e_os   = 6'(c - s0);
         e_done = (c == s0 + 63);
      end
      return {1'b1, e_done, e_le, e_ns, e_is, e_os, e_p};
   endfunction

   task automatic sweep(input bit which, input bit zero, input bit clr0,
                        input int restart_cyc, input int clear_cyc, input int abort_cyc);
      int settle = which ? 0 : 2;
      int last   = 66 + settle + 63;
      int dones  = 0;
      logic [143:0] o;
      @(negedge clk);
      if (which) start_b = 1'b1;
      else       start_a = 1'b1;
      clear_a = clr0;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      clear_a = 1'b0;
      for (int c = 1; c <= last; c++) begin
         o = which ? obs_b : obs_a;
         check($sformatf("sweep%0d_cyc%0d", which, c), o, exp_vec(c, zero, settle));
         if (o[142]) dones++;
         start_a = (c == restart_cyc) && !which;
         clear_a = (c == clear_cyc);
         if (c == abort_cyc) begin
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            o = which ? obs_b : obs_a;
            check("abort_outputs", o, '0);
            check("abort_no_done", 144'(dones), 144'(0));
            return;
         end
         @(posedge clk);
         #1;
      end
      start_a = 1'b0;
      clear_a = 1'b0;
      o = which ? obs_b : obs_a;
      check($sformatf("sweep%0d_idle_after", which), o, '0);
      check($sformatf("sweep%0d_done_pulses", which), 144'(dones), 144'(1));
   endtask

   initial begin
      rst_n   = 1'b0;
      start_a = 1'b0;
      clear_a = 1'b0;
      start_b = 1'b0;
      clear_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_a", obs_a, '0);
      check("reset_b", obs_b, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: empty buffer restores zeros, STORE captures {16{k}}
      sweep(1'b0, 1'b1, 1'b0, 0, 0, 0);
      // 2: second sweep restores what was stored
      sweep(1'b0, 1'b0, 1'b0, 0, 0, 0);
      // 3: start mid-sweep is ignored
      sweep(1'b0, 1'b0, 1'b0, 10, 0, 0);
      // 4: reset during STORE at cnt=20 aborts, then buffer reads as empty
      sweep(1'b0, 1'b0, 1'b0, 0, 0, 88);
      sweep(1'b0, 1'b1, 1'b0, 0, 0, 0);
      // 5: start+clear together restores zeros; STORE repopulates; clear in LOAD ignored
      sweep(1'b0, 1'b1, 1'b1, 0, 0, 0);
      sweep(1'b0, 1'b0, 1'b0, 0, 30, 0);
      // 6: SETTLE=0 instance
      sweep(1'b1, 1'b1, 1'b0, 0, 0, 0);
      sweep(1'b1, 1'b0, 1'b0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/potential_sweeper.md
Name: potential_sweeper

Overview:
- Sequencing master for neuron_selector: drives cntrl_potential_in_sel, cntrl_potential_out_sel and the 128-bit group slices across the 64 neuron groups of 16 neurons each.
- Holds the membrane-potential state buffer (64 x 128 b) between time steps.
- Per time step: restores stored potentials into the neuron array group by group (LOAD), pulses the neuron step (EVAL), then reads back the new potentials group by group and stores them (STORE).

Parameters:
- GROUPS, 64, number of 16-neuron groups.
- GROUP_W, 128, bits per group slice (16 neurons x 8 b).
- SEL_W, 6, group select width; must equal clog2(GROUPS).
- SETTLE, 2, wait cycles after neuron_step before STORE begins; 0 is legal.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin one time-step sweep; sampled only in IDLE
- clear  in  1  invalidate all stored potentials; honoured only in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on the last STORE cycle
- cntrl_potential_in_sel  out  SEL_W  group being restored
- potential_in_16n  out  GROUP_W  restored potential slice
- potential_load_en  out  1  high only in LOAD; gates the per-group input enables downstream
- neuron_step  out  1  one-cycle integrate strobe to the neuron array
- cntrl_potential_out_sel  out  SEL_W  group being captured
- potential_out_16n  in  GROUP_W  selected potential slice returned by neuron_selector, combinational from cntrl_potential_out_sel

Behaviour:
- Reset: clock and reset are decided as one clock (clk) with a synchronous, active-low reset (rst_n).
  - On rst_n low at a clk edge: state goes to IDLE and the group counter to 0.
  - valid[63:0] is cleared; all outputs go to 0.
  - Buffer contents are not reset; valid gates their use.
  - Reset mid-sweep aborts the sweep immediately; no done pulse is produced.
- FSM states: IDLE, LOAD, STEP, SETTLE, STORE.
  - IDLE: if start=1, go to LOAD with cnt=0. Start in any other state is ignored; there is no queueing.
  - LOAD (GROUPS cycles): registered outputs drive cntrl_potential_in_sel=cnt, potential_in_16n=(valid[cnt] ? buf[cnt] : 0) and potential_load_en=1 in the same cycle. cnt increments each cycle; after cnt=GROUPS-1, go to STEP.
  - STEP (1 cycle): neuron_step=1. Go to SETTLE if SETTLE>0, else go straight to STORE.
  - SETTLE: wait SETTLE cycles with a down-counter, then go to STORE with cnt=0.
  - STORE (GROUPS cycles): cntrl_potential_out_sel=cnt. At the clk edge, buf[cnt] is written from potential_out_16n and valid[cnt] is set. done=1 during the cnt=GROUPS-1 cycle; the next state is IDLE.
- Sweep latency: start is sampled at edge 0 and done is high in cycle GROUPS+1+SETTLE+GROUPS (131 at default parameters).
- Output values outside their active states:
  - potential_in_16n=0 and potential_load_en=0 outside LOAD.
  - cntrl_potential_in_sel and cntrl_potential_out_sel hold 0 outside LOAD and STORE respectively.
- clear:
  - In IDLE, clear zeroes valid at the edge.
  - start and clear in the same IDLE cycle: both take effect, and the LOAD phase restores zeros for every group.
  - clear outside IDLE is ignored.
- Buffer:
  - One write port (STORE) and one read port (LOAD), never active in the same cycle.
  - The read is combinational into the registered output stage, so data and select are cycle-aligned at the outputs.
- cnt is SEL_W wide and saturates/resets explicitly; it never relies on wrap-around beyond the GROUPS-1 terminal test.

Optional Feature:
- Macro: POTENTIAL_SWEEPER_DBG_EN.
- When defined, adds two ports:
  - dbg_sel, in, SEL_W
  - dbg_potential, out, GROUP_W: registered buf[dbg_sel] (or 0 if !valid[dbg_sel]), 1-cycle latency, readable in any state.
  - A dbg read of a group being written in the same cycle returns the old value.
- When undefined, neither port exists and no extra read port is inferred.

Decomposition:
- Shared package: the FSM state enum (IDLE, LOAD, STEP, SETTLE, STORE), NUM_GROUPS=64, NEURONS_PER_GROUP=16, POT_W=8, and the derived GROUP_W/SEL_W.
- One sub-module, potential_buffer: GROUPS x GROUP_W storage plus the valid bitmap, with one write port, one read port (two when DBG_EN is defined) and a clear input.

Test Plan:
1. Reset then start with the neuron model returning out slice = {16{group_index}} -> LOAD drives all-zero data for sel 0..63 with potential_load_en=1; neuron_step pulses once at cycle 65; done is high at cycle 131; all valid bits are set afterwards.
2. Second start -> LOAD cycle k drives potential_in_16n={16{8'(k)}} with cntrl_potential_in_sel=k, for k=0..63.
3. start asserted at cycle 10 of a sweep -> ignored; exactly one done pulse; busy is continuously high from cycle 1 to cycle 131.
4. rst_n low during STORE at cnt=20 -> next cycle busy=0, all outputs 0, no done; a following sweep loads zeros for all groups.
5. After a sweep, start+clear in the same IDLE cycle -> the LOAD phase drives zeros; STORE repopulates the buffer.
6. With SETTLE=0 -> STORE begins the cycle after STEP; done is high at cycle 129.
